vdp_super_pixel_fetch: RTL and testbench

Parametrised pixel fetcher for the VDP super modes. It reads packed pixel data from SDRAM as 32-bit words through a request/acknowledge port. It supports 8, 4 and 2 bits per pixel, with optional horizontal and vertical pixel doubling and a line-buffer replay for doubled lines. Each cycle it emits one registered palette index to the palette RAM read port. It sits between the view-port/timing logic (which supplies `line_start`, `frame_start` and `visible`) and the palette lookup that drives the RGB outputs.

---
 rtl/vdp_super_pixel_fetch.sv | 238 +++++++++++++++++++++++
 tb/tb_vdp_super_pixel_fetch.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vdp_super_pixel_fetch
// Brief    : SDRAM word fetcher and pixel unpacker for the VDP super modes,
//            with horizontal/vertical doubling and line-buffer replay.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_super_pixel_fetch #(
  parameter int ADDR_W    = 17,
  parameter int BUF_DEPTH = 360
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              visible,
  input  logic [1:0]        bpp_mode,
  input  logic              h_double,
  input  logic              v_double,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        palette_bank,
  input  logic [7:0]        border_index,
  input  logic              disp_on,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [31:0]       vram_data,
  output logic [7:0]        palette_addr,
  output logic              pixel_valid,
  output logic              underrun
);

  localparam int                 c_PTR_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_DEPTH    = c_PTR_W'(BUF_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = {{(c_PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_ACTIVE   = 2'd2,
    S_REPLAY   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_vram_addr;
  logic [ADDR_W-1:0]  r_line_addr;
  logic               r_odd_line;
  logic               r_underrun;
  logic               r_drain;
  logic               r_vis_d;
  logic               r_phase;
  logic [31:0]        r_fifo [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [3:0]         r_sub;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [7:0]         r_line_buf [BUF_DEPTH];
  logic [7:0]         r_pal;
  logic               r_valid;

  logic        w_rst;
  logic        w_odd_eff;
  logic        w_line_src;
  logic        w_line_rep;
  logic        w_fetch_st;
  logic        w_src_end;
  logic        w_src;
  logic        w_rep;
  logic        w_empty;
  logic        w_step;
  logic        w_adv;
  logic        w_last;
  logic        w_pop;
  logic        w_push;
  logic [3:0]  w_last_idx;
  logic [7:0]  w_pix;
  logic [31:0] w_head;

  assign w_rst      = reset || !enable;
  // frame_start is applied before a coincident line_start
  assign w_odd_eff  = frame_start ? 1'b0 : r_odd_line;
  assign w_line_src = line_start && (!v_double || !w_odd_eff);
  assign w_line_rep = line_start && v_double && w_odd_eff;
  assign w_fetch_st = (r_state == S_PREFETCH) || (r_state == S_ACTIVE);
  assign w_src_end  = (r_state == S_ACTIVE) && !visible;
  assign w_src      = w_fetch_st && visible;
  assign w_rep      = (r_state == S_REPLAY) && visible;
  assign w_empty    = (r_count == 2'd0);
  assign w_step     = !h_double || r_phase;
  assign w_adv      = w_src && !w_empty && w_step;
  assign w_last     = (r_sub >= w_last_idx);
  assign w_pop      = w_adv && w_last;
  assign w_push     = vram_ack && vram_req && w_fetch_st && !w_src_end && !r_drain;
  assign w_head     = r_fifo[r_rd_ptr];

  always_comb begin
    w_last_idx = 4'd3;
    w_pix      = w_head[{r_sub[1:0], 3'b000} +: 8];
    case (bpp_mode)
      2'd1: begin
        w_last_idx = 4'd7;
        w_pix      = {palette_bank[3:0], w_head[{r_sub[2:0], 2'b00} +: 4]};
      end
      2'd2: begin
        w_last_idx = 4'd15;
        w_pix      = {palette_bank, w_head[{r_sub, 1'b0} +: 2]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    vram_req    = r_drain || (w_fetch_st && (r_count != 2'd2));
    if (w_line_src) begin
      w_state_nxt = S_PREFETCH;
    end else if (w_line_rep) begin
      w_state_nxt = S_REPLAY;
    end else begin
      case (r_state)
        S_PREFETCH: if (visible)              w_state_nxt = S_ACTIVE;
        S_ACTIVE:   if (!visible)             w_state_nxt = S_IDLE;
        S_REPLAY:   if (r_vis_d && !visible)  w_state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_vram_addr <= '0;
      r_line_addr <= '0;
      r_odd_line  <= 1'b0;
      r_underrun  <= 1'b0;
      r_drain     <= 1'b0;
      r_vis_d     <= 1'b0;
      r_phase     <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_sub       <= 4'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_vis_d <= visible;

      if (w_src && w_empty) r_underrun <= 1'b1;
      if (frame_start) begin
        r_line_addr <= base_addr;
        r_underrun  <= 1'b0;
      end else if (w_src_end) begin
        // restart the next source line at the oldest word not yet consumed
        r_line_addr <= r_vram_addr - {{(ADDR_W-2){1'b0}}, r_count};
      end

      if (v_double && line_start) r_odd_line <= !w_odd_eff;
      else if (frame_start || !v_double) r_odd_line <= 1'b0;

      if (w_line_src || w_line_rep) r_drain <= 1'b0;
      else if (w_src_end && vram_req && !vram_ack) r_drain <= 1'b1;
      else if (vram_ack) r_drain <= 1'b0;

      if (!visible) r_phase <= 1'b0;
      else if (w_rep || (w_src && !w_empty)) r_phase <= !r_phase;

      if (w_line_src) begin
        r_vram_addr <= frame_start ? base_addr : r_line_addr;
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_count     <= 2'd0;
        r_sub       <= 4'd0;
        r_wptr      <= '0;
      end else begin
        if (w_push) begin
          r_vram_addr <= r_vram_addr + c_ADDR_ONE;
          r_wr_ptr    <= !r_wr_ptr;
        end
        if (w_adv) r_sub <= w_last ? 4'd0 : r_sub + 4'd1;
        if (w_pop) r_rd_ptr <= !r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_adv && (r_wptr < c_DEPTH)) r_wptr <= r_wptr + c_PTR_ONE;
      end

      if (w_line_rep) r_rptr <= '0;
      else if (w_rep && w_step && (r_rptr < c_DEPTH)) r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_rst && !w_line_src && w_push) r_fifo[r_wr_ptr] <= vram_data;
  end

  always_ff @(posedge clk) begin
    if (!w_rst && !w_line_src && w_adv && (r_wptr < c_DEPTH)) r_line_buf[r_wptr] <= w_pix;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_pal   <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_src) begin
      if (w_empty) begin
        r_pal   <= border_index;
        r_valid <= 1'b0;
      end else begin
        r_pal   <= disp_on ? w_pix : 8'h00;
        r_valid <= 1'b1;
      end
    end else if (w_rep && (r_rptr < c_DEPTH)) begin
      r_pal   <= disp_on ? r_line_buf[r_rptr] : 8'h00;
      r_valid <= 1'b1;
    end else begin
      r_pal   <= border_index;
      r_valid <= 1'b0;
    end
  end

  assign vram_addr    = r_vram_addr;
  assign palette_addr = r_pal;
  assign pixel_valid  = r_valid;
  assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vdp_super_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_super_pixel_fetch
// Brief    : Directed bench for vdp_super_pixel_fetch with a small VRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_super_pixel_fetch;

  localparam int ADDR_W    = 17;
  localparam int BUF_DEPTH = 360;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              visible = 1'b0;
  logic [1:0]        bpp_mode = 2'd0;
  logic              h_double = 1'b0;
  logic              v_double = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [5:0]        palette_bank = 6'd0;
  logic [7:0]        border_index = 8'hEE;
  logic              disp_on = 1'b1;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack = 1'b0;
  logic [31:0]       vram_data = 32'd0;
  logic [7:0]        palette_addr;
  logic              pixel_valid;
  logic              underrun;

  int          n_vec = 0;
  int          n_bad = 0;
  logic        stall = 1'b0;
  int          arb_cnt = 0;
  logic [31:0] mem [1024];

  vdp_super_pixel_fetch #(.ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .line_start(line_start), .visible(visible), .bpp_mode(bpp_mode),
    .h_double(h_double), .v_double(v_double), .base_addr(base_addr),
    .palette_bank(palette_bank), .border_index(border_index), .disp_on(disp_on),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_data(vram_data), .palette_addr(palette_addr),
    .pixel_valid(pixel_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // VRAM arbiter: acks a request on its second cycle, one-cycle ack pulse
  always @(negedge clk) begin
    if (vram_ack) begin
      vram_ack = 1'b0;
      arb_cnt  = 0;
    end else if (vram_req && !stall) begin
      arb_cnt = arb_cnt + 1;
      if (arb_cnt >= 2) begin
        vram_ack  = 1'b1;
        vram_data = mem[vram_addr[9:0]];
        arb_cnt   = 0;
      end
    end else begin
      arb_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base);
    base_addr   = base;
    frame_start = 1'b1;
    line_start  = 1'b1;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    repeat (10) step();
  endtask

  task automatic end_line();
    visible = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_vec++; if (vram_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", vram_req); end
    n_vec++; if (vram_addr !== 17'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000", vram_addr); end
    n_vec++; if (palette_addr !== 8'h00) begin n_bad++; $display("FAIL reset_pal: got %h want 00", palette_addr); end
    n_vec++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
    n_vec++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    reset = 1'b0;
    step();
    n_vec++; if (palette_addr !== 8'hEE) begin n_bad++; $display("FAIL idle_border: got %h want ee", palette_addr); end
  endtask

  task automatic test_8bpp();
    int   errs;
    logic [7:0] exp;
    mem[10'h100] = 32'h04030201;
    mem[10'h101] = 32'h08070605;
    mem[10'h102] = 32'h0C0B0A09;
    mem[10'h103] = 32'h100F0E0D;
    bpp_mode = 2'd0;
    start_frame(17'h00100);
    n_vec++; if (vram_addr !== 17'h00102) begin n_bad++; $display("FAIL 8bpp_prefetch_addr: got %h want 00102", vram_addr); end
    n_vec++; if (vram_req !== 1'b0) begin n_bad++; $display("FAIL 8bpp_full_req: got %b want 0", vram_req); end
    visible = 1'b1;
    step();
    n_vec++; if (palette_addr !== 8'h01 || pixel_valid !== 1'b1) begin
      n_bad++; $display("FAIL 8bpp_first: got %h/%b want 01/1", palette_addr, pixel_valid); end
    errs = 0;
    for (int j = 1; j < 16; j++) begin
      step();
      exp = 8'(j + 1);
      if (palette_addr !== exp || pixel_valid !== 1'b1) begin
        if (errs == 0) $display("FAIL 8bpp_seq: pixel %0d got %h want %h", j, palette_addr, exp);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    visible = 1'b0;
    step();
    n_vec++; if (palette_addr !== 8'hEE || pixel_valid !== 1'b0) begin
      n_bad++; $display("FAIL 8bpp_border: got %h/%b want ee/0", palette_addr, pixel_valid); end
    n_vec++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL 8bpp_no_underrun: got %b want 0", underrun); end
    repeat (10) step();
  endtask

  task automatic test_4bpp_hdouble();
    int   errs;
    int   nib;
    logic [31:0] w;
    logic [7:0]  exp;
    mem[10'h200] = 32'h000000F3;
    mem[10'h201] = 32'h87654321;
    mem[10'h202] = 32'h00000000;
    bpp_mode     = 2'd1;
    h_double     = 1'b1;
    palette_bank = 6'h0A;
    start_frame(17'h00200);
    visible = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nib = i / 2;
      w   = (nib < 8) ? mem[10'h200] : mem[10'h201];
      exp = {4'hA, 4'((w >> (4 * (nib % 8))) & 32'hF)};
      if (palette_addr !== exp) begin
        if (errs == 0) $display("FAIL 4bpp_hdouble: out %0d got %h want %h", i, palette_addr, exp);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    end_line();
    h_double = 1'b0;
  endtask

  task automatic test_2bpp();
    logic [7:0] exp [6];
    int errs;
    exp[0] = 8'h54; exp[1] = 8'h55; exp[2] = 8'h56;
    exp[3] = 8'h57; exp[4] = 8'h54; exp[5] = 8'h54;
    mem[10'h280] = 32'h000000E4;
    mem[10'h281] = 32'h0;
    bpp_mode     = 2'd2;
    palette_bank = 6'h15;
    start_frame(17'h00280);
    visible = 1'b1;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (palette_addr !== exp[i]) begin
        if (errs == 0) $display("FAIL 2bpp_seq: out %0d got %h want %h", i, palette_addr, exp[i]);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    end_line();
    bpp_mode = 2'd0;
  endtask

  task automatic test_vdouble();
    int   errs;
    int   req_hi;
    logic [7:0] exp;
    for (int w = 0; w < 96; w++)
      for (int k = 0; k < 4; k++)
        mem[10'h300 + w][8*k +: 8] = 8'((4 * w + k) * 7 + 3);
    v_double = 1'b1;
    start_frame(17'h00300);
    visible = 1'b1;
    errs = 0;
    for (int j = 0; j < 360; j++) begin
      step();
      exp = 8'(j * 7 + 3);
      if (palette_addr !== exp) begin
        if (errs == 0) $display("FAIL vdbl_source: pixel %0d got %h want %h", j, palette_addr, exp);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    end_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    req_hi = 0;
    repeat (10) begin step(); if (vram_req !== 1'b0) req_hi++; end
    visible = 1'b1;
    errs = 0;
    for (int j = 0; j < 365; j++) begin
      step();
      if (vram_req !== 1'b0) req_hi++;
      exp = (j < 360) ? 8'(j * 7 + 3) : 8'hEE;
      if (palette_addr !== exp) begin
        if (errs == 0) $display("FAIL vdbl_replay: pixel %0d got %h want %h", j, palette_addr, exp);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    n_vec++; if (req_hi != 0) begin n_bad++; $display("FAIL vdbl_no_req: got %0d req cycles want 0", req_hi); end
    end_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    n_vec++; if (vram_addr !== 17'h0035A) begin n_bad++; $display("FAIL vdbl_next_addr: got %h want 0035a", vram_addr); end
    v_double = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_underrun();
    int   errs;
    int   borders;
    int   nxt;
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++)
        mem[10'h040 + w][8*k +: 8] = 8'(4 * w + k + 1);
    start_frame(17'h00040);
    visible = 1'b1;
    stall   = 1'b1;
    errs = 0; borders = 0; nxt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 9) stall = 1'b0;
      if (pixel_valid === 1'b1) begin
        if (palette_addr !== 8'(nxt)) begin
          if (errs == 0) $display("FAIL ur_seq: got %h want %h", palette_addr, 8'(nxt));
          errs++;
        end
        nxt++;
      end else if (palette_addr === 8'hEE) begin
        borders++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    n_vec++; if (borders == 0) begin n_bad++; $display("FAIL ur_border: got %0d border outputs want >0", borders); end
    n_vec++; if (nxt < 25) begin n_bad++; $display("FAIL ur_progress: got %0d pixels want >=24", nxt - 1); end
    n_vec++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_flag: got %b want 1", underrun); end
    end_line();
    n_vec++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_vec++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL ur_clear: got %b want 0", underrun); end
  endtask

  task automatic test_reset_midline();
    logic seen;
    start_frame(17'h00100);
    visible = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (vram_req === 1'b1) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL mid_req_seen: got 0 want 1"); end
    reset = 1'b1;
    step();
    n_vec++; if (vram_req !== 1'b0 || palette_addr !== 8'h00 || pixel_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got req=%b pal=%h want req=0 pal=00", vram_req, palette_addr); end
    reset = 1'b0;
    step();
    n_vec++; if (vram_req !== 1'b0 || palette_addr !== 8'hEE || pixel_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_idle: got req=%b pal=%h want req=0 pal=ee", vram_req, palette_addr); end
    end_line();
  endtask

  task automatic test_wrap();
    logic moved;
    int   errs;
    mem[10'h3FF] = 32'hAABBCCDD;
    mem[10'h000] = 32'h11223344;
    mem[10'h001] = 32'h55667788;
    disp_on     = 1'b0;
    base_addr   = 17'h1FFFF;
    frame_start = 1'b1;
    line_start  = 1'b1;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    n_vec++; if (vram_addr !== 17'h1FFFF) begin n_bad++; $display("FAIL wrap_start: got %h want 1ffff", vram_addr); end
    moved = 1'b0;
    for (int i = 0; i < 10 && !moved; i++) begin
      step();
      if (vram_addr !== 17'h1FFFF) moved = 1'b1;
    end
    n_vec++; if (vram_addr !== 17'h00000) begin n_bad++; $display("FAIL wrap_addr: got %h want 00000", vram_addr); end
    repeat (8) step();
    visible = 1'b1;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (palette_addr !== 8'h00 || pixel_valid !== 1'b1) begin
        if (errs == 0) $display("FAIL wrap_dispoff: got %h/%b want 00/1", palette_addr, pixel_valid);
        errs++;
      end
    end
    n_vec++; if (errs != 0) n_bad++;
    end_line();
    disp_on = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_8bpp();
    test_4bpp_hdouble();
    test_2bpp();
    test_vdouble();
    test_underrun();
    test_reset_midline();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
